mem_port_arbiter: RTL and testbench

//  Shares the single-port main memory (clock/address/data_in/access_size/rw/enable -> data_out/busy)

---
 rtl/mem_arb_pkg.sv | 41 ++++
 rtl/mem_burst_addr_gen.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter: burst sizes, FSM states,
// rw encoding, port identifiers and burst-length helpers.
package mem_arb_pkg;

    localparam logic [1:0] SIZE_1  = 2'b00;
    localparam logic [1:0] SIZE_4  = 2'b01;
    localparam logic [1:0] SIZE_8  = 2'b10;
    localparam logic [1:0] SIZE_16 = 2'b11;

    // Memory rw encoding: 1 = read, 0 = write
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_BURST = 2'b01;
    localparam logic [1:0] ST_DRAIN = 2'b10;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    // Number of words in a burst of the given size encoding
    function automatic logic [4:0] burst_len(input logic [1:0] size);
        case (size)
            SIZE_1:  return 5'd1;
            SIZE_4:  return 5'd4;
            SIZE_8:  return 5'd8;
            default: return 5'd16;
        endcase
    endfunction

    // Index of the final beat (len-1); always fits the 4-bit beat counter
    function automatic logic [3:0] burst_last_beat(input logic [1:0] size);
        case (size)
            SIZE_1:  return 4'd0;
            SIZE_4:  return 4'd3;
            SIZE_8:  return 4'd7;
            default: return 4'd15;
        endcase
    endfunction

endpackage

// File: rtl/mem_burst_addr_gen.sv
// Burst address generator: holds the word-aligned base and beat counter,
// produces base + 4*beat (wrapping modulo 2^ADDR_WIDTH) and a last-beat flag.
module mem_burst_addr_gen
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] base_in,
    input  logic [1:0]            size_in,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  last
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    logic [ADDR_WIDTH-1:0] base_q;
    logic [3:0]            beat_q;
    logic [3:0]            last_beat_q;

    // Capture base/length on a new grant; step the beat on each accepted beat
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            base_q      <= '0;
            beat_q      <= '0;
            last_beat_q <= '0;
        end else if (load) begin
            base_q      <= base_in & ALIGN_MASK;
            beat_q      <= '0;
            last_beat_q <= burst_last_beat(size_in);
        end else if (advance) begin
            beat_q      <= beat_q + 4'd1;
        end
    end

    assign last    = (beat_q == last_beat_q);
    assign address = base_q + {{(ADDR_WIDTH-6){1'b0}}, beat_q, 2'b00};

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port memory between the ifetch (read-only) and load/store
// ports: round-robin-on-tie arbitration, burst sequencing with busy stalls,
// and a registered read-return path with per-port valid/done strobes.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [1:0]            i_size,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_done,
    input  logic                  d_req,
    input  logic                  d_rw,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [1:0]            d_size,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_wready,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_done,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic [1:0]            mem_access_size,
    output logic                  mem_rw,
    output logic                  mem_enable,
    input  logic                  mem_busy,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    logic [1:0]            state_q;
    logic                  ptr_q;     // port that wins a tie
    logic                  owner_q;   // port owning the current burst
    logic                  rw_q;
    logic [1:0]            size_q;
    logic                  rv_q;      // read beat accepted last cycle
    logic                  in_idle, in_burst, in_drain;
    logic                  win_d, start, accept, last;
    logic [ADDR_WIDTH-1:0] gen_address;

    assign in_idle  = (state_q == ST_IDLE);
    assign in_burst = (state_q == ST_BURST);
    assign in_drain = (state_q == ST_DRAIN);

    // Data port wins when alone or when it holds the tie pointer. Grant is
    // gated by reset_n so outputs stay quiet while reset is asserted.
    assign win_d  = d_req && (!i_req || ptr_q == PORT_D);
    assign start  = reset_n && in_idle && (i_req || d_req);
    assign accept = in_burst && !mem_busy;

    mem_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (start),
        .base_in (win_d ? d_addr : i_addr),
        .size_in (win_d ? d_size : i_size),
        .advance (accept),
        .address (gen_address),
        .last    (last)
    );

    // FSM, arbitration pointer, burst attributes and read-return strobe
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= PORT_D;
            owner_q <= PORT_IF;
            rw_q    <= 1'b0;
            size_q  <= 2'b00;
            rv_q    <= 1'b0;
        end else begin
            rv_q <= accept && (rw_q == RW_READ);
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_BURST;
                        owner_q <= win_d ? PORT_D : PORT_IF;
                        ptr_q   <= win_d ? PORT_IF : PORT_D;
                        rw_q    <= win_d ? d_rw : RW_READ;
                        size_q  <= win_d ? d_size : i_size;
                    end
                end
                ST_BURST: begin
                    if (accept && last)
                        state_q <= (rw_q == RW_READ) ? ST_DRAIN : ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign i_gnt = start && !win_d;
    assign d_gnt = start && win_d;

    assign mem_enable      = in_burst;
    assign mem_address     = in_burst ? gen_address : '0;
    assign mem_access_size = size_q;
    assign mem_rw          = rw_q;
    assign mem_data_in     = (in_burst && rw_q == RW_WRITE) ? d_wdata : '0;

    // Only the data port ever writes, so no owner qualification is needed
    assign d_wready = accept && (rw_q == RW_WRITE);

    assign i_rvalid = rv_q && (owner_q == PORT_IF);
    assign d_rvalid = rv_q && (owner_q == PORT_D);
    assign i_rdata  = i_rvalid ? mem_data_out : '0;
    assign d_rdata  = d_rvalid ? mem_data_out : '0;

    assign i_done = in_drain && (owner_q == PORT_IF);
    assign d_done = (in_drain && owner_q == PORT_D) || (d_wready && last);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: grants push expected memory beats and read returns
// (computed from a reference memory and the arbitration rules); a monitor
// pops and compares whenever the DUT presents a beat or read data.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clock = 1'b0, reset_n = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_rw = 1'b0, mem_busy = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_data_out = '0;
    logic [1:0]  i_size = '0, d_size = '0;
    logic        i_gnt, i_rvalid, i_done, d_gnt, d_wready, d_rvalid, d_done;
    logic [31:0] i_rdata, d_rdata, mem_address, mem_data_in;
    logic [1:0]  mem_access_size;
    logic        mem_rw, mem_enable;

    always #5 clock = ~clock;

    mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_size(i_size), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_size(d_size), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_wready(d_wready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_access_size(mem_access_size),
        .mem_rw(mem_rw), .mem_enable(mem_enable), .mem_busy(mem_busy), .mem_data_out(mem_data_out)
    );

    int n_tests = 0, n_fail = 0, cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tfail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Background contents of never-written words
    function automatic logic [31:0] pat(input logic [7:0] i);
        return {i, ~i, 16'h5A3C};
    endfunction

    // Memory model: 256 words aliased over the address space, read data one cycle after accept
    logic [31:0] mem [256];
    bit          written [256];
    always @(posedge clock) begin
        if (mem_enable && !mem_busy) begin
            if (mem_rw) begin
                mem_data_out <= written[mem_address[9:2]] ? mem[mem_address[9:2]] : pat(mem_address[9:2]);
            end else begin
                mem[mem_address[9:2]]     <= mem_data_in;
                written[mem_address[9:2]] <= 1'b1;
            end
        end else begin
            mem_data_out <= $urandom;
        end
    end

    // Busy source: random stalls or a scripted level
    int   busy_mode  = 0;
    logic busy_force = 1'b0;
    always @(posedge clock) begin
        #1;
        if (busy_mode == 1) mem_busy = ($urandom_range(0, 3) == 0);
        else                mem_busy = busy_force;
    end

    // Reference model state
    typedef struct packed {logic [31:0] addr; logic rw; logic [1:0] size; logic [31:0] wdata; logic last;} beat_t;
    typedef struct packed {logic port; logic [31:0] data; logic last;} rd_t;
    beat_t       bq[$];
    rd_t         rq[$];
    logic        ref_ptr = PORT_D;
    logic [31:0] ref_mem [256];
    bit          ref_wr [256];
    logic [31:0] wbuf [16];

    // Monitor / scoreboard
    initial begin
        logic        exp_d, rw, port;
        logic [31:0] base, a;
        logic [1:0]  sz;
        logic [7:0]  idx;
        int          len;
        beat_t       b;
        rd_t         r;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                bq.delete();
                rq.delete();
                ref_ptr = PORT_D;
                continue;
            end
            // Grant: check winner against the arbitration rule, then queue expectations
            if (i_gnt || d_gnt) begin
                exp_d = d_req && (!i_req || ref_ptr == PORT_D);
                check("gnt_winner", {30'd0, i_gnt, d_gnt}, exp_d ? 32'd1 : 32'd2);
                check("gnt_while_busy", bq.size() + rq.size(), 0);
                ref_ptr = exp_d ? PORT_IF : PORT_D;
                port = exp_d;
                rw   = exp_d ? d_rw : RW_READ;
                base = exp_d ? d_addr : i_addr;
                base[1:0] = 2'b00;
                sz   = exp_d ? d_size : i_size;
                len  = int'(burst_len(sz));
                for (int k = 0; k < len; k++) begin
                    a   = base + 32'(4 * k);
                    idx = a[9:2];
                    bq.push_back('{a, rw, sz, (rw == RW_WRITE) ? wbuf[k] : 32'd0, k == len - 1});
                    if (rw == RW_READ) begin
                        rq.push_back('{port, ref_wr[idx] ? ref_mem[idx] : pat(idx), k == len - 1});
                    end else begin
                        ref_mem[idx] = wbuf[k];
                        ref_wr[idx]  = 1'b1;
                    end
                end
            end
            // Memory-side beat: address held during stalls, attributes and data on accept
            if (mem_enable) begin
                if (bq.size() == 0) tfail("unexpected_mem_beat");
                else begin
                    b = bq[0];
                    check("mem_address", mem_address, b.addr);
                    if (b.rw == RW_WRITE) check("mem_data_in", mem_data_in, b.wdata);
                    if (!mem_busy) begin
                        check("mem_rw", {31'd0, mem_rw}, {31'd0, b.rw});
                        check("mem_size", {30'd0, mem_access_size}, {30'd0, b.size});
                        check("d_wready", {31'd0, d_wready}, {31'd0, b.rw == RW_WRITE});
                        if (b.rw == RW_WRITE) check("d_done_write", {31'd0, d_done}, {31'd0, b.last});
                        void'(bq.pop_front());
                    end else begin
                        check("wready_on_stall", {31'd0, d_wready}, 32'd0);
                    end
                end
            end
            // Read return path
            if (i_rvalid || d_rvalid) begin
                if (rq.size() == 0) tfail("unexpected_rvalid");
                else begin
                    r = rq.pop_front();
                    check("rvalid_port", {30'd0, i_rvalid, d_rvalid}, (r.port == PORT_D) ? 32'd1 : 32'd2);
                    check("rdata", (r.port == PORT_D) ? d_rdata : i_rdata, r.data);
                    check("rdone", {31'd0, (r.port == PORT_D) ? d_done : i_done}, {31'd0, r.last});
                end
            end else begin
                if (i_done) tfail("i_done_without_rvalid");
                if (d_done && !d_wready) tfail("d_done_without_beat");
            end
        end
    end

    task automatic do_if(input logic [31:0] a, input logic [1:0] s);
        bit ok = 0;
        @(posedge clock); #1;
        i_addr = a; i_size = s; i_req = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clock);
            if (i_gnt) begin ok = 1; break; end
        end
        @(posedge clock); #1;
        i_req = 1'b0; i_addr = $urandom; i_size = 2'($urandom);
        if (!ok) begin tfail("i_gnt_timeout"); return; end
        ok = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clock);
            if (i_done) begin ok = 1; break; end
        end
        if (!ok) tfail("i_done_timeout");
    endtask

    task automatic do_d(input logic rw, input logic [31:0] a, input logic [1:0] s);
        bit ok = 0;
        int idx = 0;
        for (int k = 0; k < 16; k++) wbuf[k] = $urandom;
        @(posedge clock); #1;
        d_rw = rw; d_addr = a; d_size = s; d_wdata = wbuf[0]; d_req = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clock);
            if (d_gnt) begin ok = 1; break; end
        end
        @(posedge clock); #1;
        d_req = 1'b0;
        if (!ok) begin tfail("d_gnt_timeout"); return; end
        ok = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clock);
            if (d_done) begin ok = 1; break; end
            if (d_wready) idx++;
            @(posedge clock); #1;
            if (idx < 16) d_wdata = wbuf[idx];
        end
        if (!ok) tfail("d_done_timeout");
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_flags"}, {21'd0, i_gnt, i_rvalid, i_done, d_gnt, d_wready, d_rvalid,
                                 d_done, mem_access_size, mem_rw, mem_enable}, 32'd0);
        check({name, "_addr"}, mem_address, 32'd0);
        check({name, "_wdata"}, mem_data_in, 32'd0);
        check({name, "_rdata"}, i_rdata | d_rdata, 32'd0);
    endtask

    initial begin
        int g, r, stray;
        // Reset state
        #12;
        check_outputs_zero("reset");
        @(posedge clock); #2;
        reset_n = 1'b1;

        // Simultaneous requests right out of reset, then two more ties
        for (int t = 0; t < 3; t++) begin
            fork
                do_d(RW_READ, $urandom, SIZE_1);
                do_if($urandom, SIZE_4);
            join
        end

        // Single-word ifetch latency: rvalid/done two cycles after grant
        @(posedge clock); #1;
        i_addr = 32'h8002_0000; i_size = SIZE_1; i_req = 1'b1;
        g = -1; r = -1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            if (i_gnt) begin g = cyc; break; end
        end
        @(posedge clock); #1;
        i_req = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            if (i_rvalid) begin r = cyc; break; end
        end
        check("if_latency", 32'(r - g), 32'd2);
        check("if_done_with_rvalid", {31'd0, i_done}, 32'd1);

        // 4-word write with a 3-cycle stall on the second beat
        fork
            do_d(RW_WRITE, 32'h8002_0000, SIZE_4);
            begin
                for (int c = 0; c < 50; c++) begin
                    @(negedge clock);
                    if (mem_enable && !mem_busy) break;
                end
                @(posedge clock);
                busy_force = 1'b1;
                repeat (3) @(posedge clock);
                busy_force = 1'b0;
            end
        join

        // Read back the same words, then a wrapping 16-word read
        do_d(RW_READ, 32'h8002_0000, SIZE_4);
        do_d(RW_READ, 32'hFFFF_FFF0, SIZE_16);

        // Random traffic on both ports with random stalls
        busy_mode = 1;
        fork
            for (int n = 0; n < 40; n++) begin
                repeat ($urandom_range(0, 3)) @(posedge clock);
                do_if($urandom, 2'($urandom));
            end
            for (int n = 0; n < 40; n++) begin
                repeat ($urandom_range(0, 3)) @(posedge clock);
                do_d(1'($urandom), $urandom, 2'($urandom));
            end
        join
        busy_mode = 0;
        repeat (3) @(posedge clock);

        // Reset in the middle of a 16-word read
        @(posedge clock); #1;
        d_rw = RW_READ; d_addr = 32'h0000_0100; d_size = SIZE_16; d_req = 1'b1;
        g = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            if (d_gnt) begin g = 1; break; end
        end
        if (g == 0) tfail("d_gnt_timeout_reset_test");
        @(posedge clock); #1;
        d_req = 1'b0;
        repeat (5) @(posedge clock);
        #3 reset_n = 1'b0;
        #1 check_outputs_zero("midburst_reset");
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (i_rvalid || d_rvalid || i_done || d_done || mem_enable) stray++;
        end
        check("no_activity_after_reset", 32'(stray), 32'd0);

        // Traffic works again after the abort
        do_if(32'h0000_0040, SIZE_8);
        repeat (3) @(posedge clock);
        check("queues_drained", 32'(bq.size() + rq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
